// File: rtl/rv_core_pkg.sv
// Shared core definitions: bubble encoding, reset vector and IF fetch FSM encoding.
package rv_core_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush, load, hold on stall, otherwise collapse to a bubble.
module if_id_register
  import rv_core_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        stall,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if,
  output logic        if_valid
);

  // pc fields keep their last value on flush/bubble; only instruction and valid change
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction  <= NOP_INSTR;
      pc_if        <= 32'h0;
      pc_plus_4_if <= 32'h0;
      if_valid     <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
    end else if (load) begin
      instruction  <= instr_in;
      pc_if        <= pc_in;
      pc_plus_4_if <= pc_inc(pc_in);
      if_valid     <= 1'b1;
    end else if (!stall) begin
      instruction <= NOP_INSTR;
      if_valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, one-entry hold buffer.
module if_fetch_stage
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if,
  output logic        if_valid
);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] hold_instr;
  logic [31:0] hold_next;
  logic        load;
  logic [31:0] load_instr;

  assign imem_req  = (state == S_REQ) & ~redirect & ~rst;
  assign imem_addr = pc;

  // A redirect while a response is still owed moves to S_DROP so the stale word is eaten.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    hold_next  = hold_instr;
    load       = 1'b0;
    load_instr = imem_rdata;
    if (redirect) begin
      pc_next = pc_align(redirect_pc);
      if ((state == S_WAIT) || (state == S_DROP)) begin
        state_next = imem_rvalid ? S_REQ : S_DROP;
      end else begin
        state_next = S_REQ;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req && imem_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (stall_id) begin
              hold_next  = imem_rdata;
              state_next = S_HOLD;
            end else begin
              load       = 1'b1;
              load_instr = imem_rdata;
              pc_next    = pc_inc(pc);
              state_next = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall_id) begin
            load       = 1'b1;
            load_instr = hold_instr;
            pc_next    = pc_inc(pc);
            state_next = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) state_next = S_REQ;
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Buffer contents are only meaningful in S_HOLD, so they carry no reset.
  always_ff @(posedge clk) begin
    hold_instr <= hold_next;
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .flush       (redirect),
    .stall       (stall_id),
    .instr_in    (load_instr),
    .pc_in       (pc),
    .instruction (instruction),
    .pc_if       (pc_if),
    .pc_plus_4_if(pc_plus_4_if),
    .if_valid    (if_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed per-cycle vector table, then randomized traffic vs a model.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall_id, redirect, imem_ready, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, instruction, pc_if, pc_plus_4_if;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .pc_if       (pc_if),
    .pc_plus_4_if(pc_plus_4_if),
    .if_valid    (if_valid)
  );

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] rpc;
    bit          ready, rvalid;
    logic [31:0] rdata;
    bit          ereq;
    logic [31:0] eaddr, einstr, epcif, epc4;
    bit          evalid, chk_reg;
  } vec_t;

  function automatic vec_t v(bit r, bit s, bit rd, logic [31:0] rpc, bit rdy, bit rv,
                             logic [31:0] rdat, bit ereq, logic [31:0] eaddr,
                             logic [31:0] einstr, logic [31:0] epcif, logic [31:0] epc4,
                             bit evalid, bit chk_reg);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = rd; t.rpc = rpc; t.ready = rdy; t.rvalid = rv;
    t.rdata = rdat; t.ereq = ereq; t.eaddr = eaddr; t.einstr = einstr; t.epcif = epcif;
    t.epc4 = epc4; t.evalid = evalid; t.chk_reg = chk_reg;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: abstract fetch bookkeeping, not the DUT's FSM encoding.
  logic [31:0] m_pc, m_instr, m_pcif, m_pc4, m_buf;
  bit          m_busy, m_want, m_buf_full, m_valid;

  function automatic bit m_req();
    return !m_busy && !m_buf_full && !redirect && !rst;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_busy = 0; m_want = 0; m_buf_full = 0;
    m_instr = NOP; m_pcif = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_step();
    bit          req, have;
    logic [31:0] word;
    req  = m_req();
    have = 0;
    word = 32'h0;
    if (rst) begin
      model_reset();
    end else if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 0; m_instr = NOP; m_buf_full = 0;
      m_busy = m_busy && !imem_rvalid;
      m_want = 0;
    end else begin
      if (req && imem_ready) begin
        m_busy = 1; m_want = 1;
      end else if (m_busy && imem_rvalid) begin
        m_busy = 0;
        if (m_want) begin
          if (stall_id) begin m_buf_full = 1; m_buf = imem_rdata; end
          else begin have = 1; word = imem_rdata; end
        end
      end else if (m_buf_full && !stall_id) begin
        have = 1; word = m_buf; m_buf_full = 0;
      end
      if (have) begin
        m_instr = word; m_pcif = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1;
        m_pc = m_pc + 32'd4;
      end else if (!stall_id) begin
        m_instr = NOP; m_valid = 0;
      end
    end
  endtask

  vec_t vecs[24];
  bit          mem_pending;
  int unsigned mem_wait;
  logic [31:0] mem_word;
  bit          req_s;

  initial begin
    vecs[0]  = v(1,0,0,0,0,0,0,               0,0,NOP,0,0,0,0);
    vecs[1]  = v(1,0,0,0,0,0,0,               0,0,NOP,0,0,0,1);
    vecs[2]  = v(0,0,0,0,1,0,0,               1,0,NOP,0,0,0,1);
    vecs[3]  = v(0,0,0,0,0,1,32'h00500093,    0,0,NOP,0,0,0,1);
    vecs[4]  = v(0,0,0,0,1,0,0,               1,4,32'h00500093,0,4,1,1);
    vecs[5]  = v(0,1,0,0,0,1,32'h00A00113,    0,4,NOP,0,4,0,1);
    vecs[6]  = v(0,1,0,0,1,0,0,               0,4,NOP,0,4,0,1);
    vecs[7]  = v(0,0,0,0,1,0,0,               0,4,NOP,0,4,0,1);
    vecs[8]  = v(0,0,0,0,1,0,0,               1,8,32'h00A00113,4,8,1,1);
    vecs[9]  = v(0,0,1,32'h100,0,0,0,         0,8,NOP,4,8,0,1);
    vecs[10] = v(0,0,0,0,0,0,0,               0,32'h100,NOP,4,8,0,1);
    vecs[11] = v(0,0,0,0,0,1,32'hDEADBEEF,    0,32'h100,NOP,4,8,0,1);
    vecs[12] = v(0,0,0,0,0,0,0,               1,32'h100,NOP,4,8,0,1);
    vecs[13] = v(0,0,0,0,1,0,0,               1,32'h100,NOP,4,8,0,1);
    vecs[14] = v(0,0,0,0,0,1,32'h00100093,    0,32'h100,NOP,4,8,0,1);
    vecs[15] = v(0,1,1,32'h203,1,0,0,         0,32'h104,32'h00100093,32'h100,32'h104,1,1);
    vecs[16] = v(0,0,0,0,0,0,0,               1,32'h200,NOP,32'h100,32'h104,0,1);
    vecs[17] = v(0,0,1,32'hFFFFFFFC,0,0,0,    0,32'h200,NOP,32'h100,32'h104,0,1);
    vecs[18] = v(0,0,0,0,1,0,0,               1,32'hFFFFFFFC,NOP,32'h100,32'h104,0,1);
    vecs[19] = v(0,0,0,0,0,1,32'h00000013,    0,32'hFFFFFFFC,NOP,32'h100,32'h104,0,1);
    vecs[20] = v(0,0,0,0,1,0,0,               1,0,32'h13,32'hFFFFFFFC,0,1,1);
    vecs[21] = v(1,0,0,0,0,0,0,               0,0,NOP,32'hFFFFFFFC,0,0,1);
    vecs[22] = v(0,0,0,0,0,1,32'hDEADBEEF,    1,0,NOP,0,0,0,1);
    vecs[23] = v(0,0,0,0,0,0,0,               1,0,NOP,0,0,0,1);

    for (int i = 0; i < 24; i++) begin
      rst = vecs[i].rst; stall_id = vecs[i].stall; redirect = vecs[i].redir;
      redirect_pc = vecs[i].rpc; imem_ready = vecs[i].ready;
      imem_rvalid = vecs[i].rvalid; imem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].ereq});
      if (vecs[i].chk_reg) begin
        chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eaddr);
        chk($sformatf("vec%0d instruction", i), instruction, vecs[i].einstr);
        chk($sformatf("vec%0d pc_if", i), pc_if, vecs[i].epcif);
        chk($sformatf("vec%0d pc_plus_4_if", i), pc_plus_4_if, vecs[i].epc4);
        chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].evalid});
      end
      @(posedge clk);
      @(negedge clk);
    end

    // Randomized phase: start from reset, memory answers 1..3 cycles after accept.
    rst = 1; stall_id = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    mem_pending = 0; mem_wait = 0; mem_word = 0;

    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      stall_id    = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFFC | redirect_pc[1:0];
      imem_ready  = ($urandom_range(0, 3) != 0);
      if (mem_pending && mem_wait == 0) begin
        imem_rvalid = 1; imem_rdata = mem_word;
      end else if (!mem_pending && $urandom_range(0, 15) == 0) begin
        imem_rvalid = 1; imem_rdata = $urandom;
      end else begin
        imem_rvalid = 0; imem_rdata = $urandom;
      end
      #1;
      req_s = m_req();
      chk($sformatf("rnd%0d imem_req", c), {31'b0, imem_req}, {31'b0, req_s});
      chk($sformatf("rnd%0d imem_addr", c), imem_addr, m_pc);
      chk($sformatf("rnd%0d instruction", c), instruction, m_instr);
      chk($sformatf("rnd%0d pc_if", c), pc_if, m_pcif);
      chk($sformatf("rnd%0d pc_plus_4_if", c), pc_plus_4_if, m_pc4);
      chk($sformatf("rnd%0d if_valid", c), {31'b0, if_valid}, {31'b0, m_valid});
      model_step();
      if (rst) begin
        mem_pending = 0;
      end else if (req_s && imem_ready) begin
        mem_pending = 1; mem_wait = $urandom_range(0, 2); mem_word = $urandom;
      end else if (mem_pending && mem_wait == 0 && imem_rvalid) begin
        mem_pending = 0;
      end else if (mem_pending && mem_wait > 0) begin
        mem_wait--;
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
